// File: rtl/pipe_if_stage_pkg.sv
// Shared encodings for the MIPS instruction-fetch stage.
package pipe_if_stage_pkg;

  localparam logic [1:0] PCSRC_PC4 = 2'b00;
  localparam logic [1:0] PCSRC_BPC = 2'b01;
  localparam logic [1:0] PCSRC_DA  = 2'b10;
  localparam logic [1:0] PCSRC_JPC = 2'b11;

  localparam logic [31:0] NOP_INST = 32'h0000_0000;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_HOLD  = 1'b1
  } if_state_e;

endpackage

// File: rtl/pipe_if_stage_next_pc_mux.sv
// Redirect target selection from the ID-stage control unit; targets are word aligned.
module if_next_pc_mux
  import pipe_if_stage_pkg::*;
(
  input  logic [1:0]  pcsource_i,
  input  logic [31:0] pc4_i,
  input  logic [31:0] bpc_i,
  input  logic [31:0] da_i,
  input  logic [31:0] jpc_i,
  output logic [31:0] tgt_o
);

  logic [31:0] sel;

  always_comb begin
    sel = pc4_i;
    case (pcsource_i)
      PCSRC_PC4: sel = pc4_i;
      PCSRC_BPC: sel = bpc_i;
      PCSRC_DA:  sel = da_i;
      PCSRC_JPC: sel = jpc_i;
      default:   sel = pc4_i;
    endcase
    tgt_o = sel & ~32'h0000_0003;
  end

endmodule

// File: rtl/pipe_if_stage.sv
// IF stage with IF/ID register: PC, handshaked imem fetch, stall hold and
// deferred redirect when a branch is accepted while memory is still busy.
module pipe_if_stage
  import pipe_if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC_P = RESET_PC,
  parameter logic [31:0] NOP_INST_P = NOP_INST
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic [1:0]  pcsource_i,
  input  logic [31:0] bpc_i,
  input  logic [31:0] da_i,
  input  logic [31:0] jpc_i,
  input  logic        wpcir_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  input  logic        imem_ready_i,
  output logic [31:0] pc_o,
  output logic [31:0] dpc4_o,
  output logic [31:0] dinst_o,
  output logic        fetch_wait_o
);

  if_state_e   state_q;
  logic [31:0] pc_q, pc_d;
  logic [31:0] dinst_q, dpc4_q, hold_q;
  logic        rd_pend_q, rd_pend_d;
  logic [31:0] rd_tgt_q, rd_tgt_d;

  logic [31:0] pc4, tgt, inst_cur;
  logic        inst_avail, advance, redirect;

  assign pc4 = pc_q + 32'd4;

  if_next_pc_mux u_next_pc_mux (
    .pcsource_i (pcsource_i),
    .pc4_i      (pc4),
    .bpc_i      (bpc_i),
    .da_i       (da_i),
    .jpc_i      (jpc_i),
    .tgt_o      (tgt)
  );

  always_comb begin
    inst_avail = ((state_q == ST_FETCH) && imem_ready_i) || (state_q == ST_HOLD);
    inst_cur   = (state_q == ST_HOLD) ? hold_q : imem_rdata_i;
    advance    = inst_avail && wpcir_i;
    redirect   = wpcir_i && (pcsource_i != PCSRC_PC4);
  end

  // A redirect that cannot advance yet is parked until the delay slot arrives.
  always_comb begin
    pc_d      = pc_q;
    rd_pend_d = rd_pend_q;
    rd_tgt_d  = rd_tgt_q;
    if (advance && redirect) begin
      pc_d = tgt;
    end else if (advance && rd_pend_q) begin
      pc_d      = rd_tgt_q;
      rd_pend_d = 1'b0;
    end else if (advance) begin
      pc_d = pc4;
    end else if (redirect) begin
      rd_pend_d = 1'b1;
      rd_tgt_d  = tgt;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= ST_FETCH;
      pc_q      <= RESET_PC_P;
      dinst_q   <= NOP_INST_P;
      dpc4_q    <= 32'h0;
      hold_q    <= 32'h0;
      rd_pend_q <= 1'b0;
      rd_tgt_q  <= 32'h0;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (imem_ready_i && !wpcir_i) begin
            state_q <= ST_HOLD;
            hold_q  <= imem_rdata_i;
          end
        end
        ST_HOLD: begin
          if (wpcir_i) state_q <= ST_FETCH;
        end
        default: state_q <= ST_FETCH;
      endcase
      pc_q      <= pc_d;
      rd_pend_q <= rd_pend_d;
      rd_tgt_q  <= rd_tgt_d;
      if (wpcir_i) begin
        dinst_q <= advance ? inst_cur : NOP_INST_P;
        dpc4_q  <= pc4;
      end
    end
  end

  assign imem_req_o   = (state_q == ST_FETCH) && !reset_i;
  assign imem_addr_o  = pc_q;
  assign pc_o         = pc_q;
  assign dpc4_o       = dpc4_q;
  assign dinst_o      = dinst_q;
  assign fetch_wait_o = (state_q == ST_FETCH) && !imem_ready_i;

endmodule
